fifo_pop_sequencer: RTL and testbench

- Sits directly downstream of the token-engine preheat/phase controllers and upstream of the ifmap/ipsum FIFOs feeding the PE rows.
- Per lane, it latches a one-cycle pop request (need_pop bit plus pop count), then issues single-cycle pop strobes to the FIFO whenever data and the PE row are ready.
- It reports completion per lane in a sticky done matrix. The controller waits on the AND of all done bits.

---
 rtl/token_engine_pkg.sv | 23 ++
 rtl/pop_lane_ctrl.sv | 95 +++++++++
 rtl/fifo_pop_sequencer.sv | 51 +++++
 tb/tb_fifo_pop_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/token_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : token_engine_pkg
// Description : Shared types and constants for the token engine datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package token_engine_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lane_state_e;

   localparam int NUM_FIFO_DEF = 32;

   typedef enum logic [0:0] {
      POINTWISE = 1'b0,
      DEPTHWISE = 1'b1
   } layer_type_e;

endpackage
`default_nettype wire

// File: rtl/pop_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pop_lane_ctrl
// Description : One FIFO lane: latches a pop count, then issues pop strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_lane_ctrl
   import token_engine_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             need_pop_i,
   input  logic [CNT_W-1:0] pop_num_i,
   input  logic             fifo_empty_i,
   input  logic             pe_ready_i,
   output logic             pop_o,
   output logic             done_o,
   output logic             busy_o,
   output logic             overrun_err_o
);

   lane_state_e      r_state;
   lane_state_e      w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_err_nxt       = r_err;
      w_pop           = 1'b0;

      if (clear_i) begin
         w_state_nxt     = IDLE;
         w_remaining_nxt = '0;
         w_err_nxt       = 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (need_pop_i) begin
                  if (pop_num_i != '0) begin
                     w_state_nxt     = BUSY;
                     w_remaining_nxt = pop_num_i;
                  end else begin
                     w_state_nxt     = DONE;
                     w_remaining_nxt = '0;
                  end
               end
            end
            BUSY: begin
               // A reload while counting is dropped; only the error flag records it.
               if (need_pop_i) begin
                  w_err_nxt = 1'b1;
               end
               w_pop = !fifo_empty_i && pe_ready_i;
               if (w_pop) begin
                  w_remaining_nxt = r_remaining - CNT_W'(1);
                  if (r_remaining == CNT_W'(1)) begin
                     w_state_nxt = DONE;
                  end
               end
            end
            default: begin
               w_state_nxt     = IDLE;
               w_remaining_nxt = '0;
            end
         endcase
      end
   end

   assign pop_o         = w_pop;
   assign done_o        = (r_state == DONE);
   assign busy_o        = (r_state == BUSY);
   assign overrun_err_o = r_err;

endmodule
`default_nettype wire

// File: rtl/fifo_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_sequencer
// Description : Per-lane FIFO pop sequencing with sticky done/overrun status.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pop_sequencer
   import token_engine_pkg::*;
#(
   parameter int NUM_FIFO = NUM_FIFO_DEF,
   parameter int CNT_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_FIFO-1:0]       need_pop_i,
   input  logic [NUM_FIFO*CNT_W-1:0] pop_num_i,
   input  logic                      clear_i,
   input  logic [NUM_FIFO-1:0]       fifo_empty_i,
   input  logic [NUM_FIFO-1:0]       pe_ready_i,
   output logic [NUM_FIFO-1:0]       pop_o,
   output logic [NUM_FIFO-1:0]       done_matrix_o,
   output logic                      busy_o,
   output logic [NUM_FIFO-1:0]       overrun_err_o
);

   logic [NUM_FIFO-1:0] w_lane_busy;

   generate
      for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_lane
         pop_lane_ctrl #(
            .CNT_W (CNT_W)
         ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .clear_i       (clear_i),
            .need_pop_i    (need_pop_i[gi]),
            .pop_num_i     (pop_num_i[gi*CNT_W +: CNT_W]),
            .fifo_empty_i  (fifo_empty_i[gi]),
            .pe_ready_i    (pe_ready_i[gi]),
            .pop_o         (pop_o[gi]),
            .done_o        (done_matrix_o[gi]),
            .busy_o        (w_lane_busy[gi]),
            .overrun_err_o (overrun_err_o[gi])
         );
      end
   endgenerate

   assign busy_o = |w_lane_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_sequencer.sv
`default_nettype none
// Scoreboard bench: a count-based lane model predicts every cycle's outputs,
// a separate monitor compares them against the sequencer.
module tb_fifo_pop_sequencer;

   localparam int N = 32;
   localparam int W = 32;

   typedef struct packed {
      logic [N-1:0] pop;
      logic [N-1:0] done;
      logic [N-1:0] err;
      logic         busy;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     need_pop_i;
   logic [N*W-1:0]   pop_num_i;
   logic             clear_i;
   logic [N-1:0]     fifo_empty_i;
   logic [N-1:0]     pe_ready_i;
   logic [N-1:0]     pop_o;
   logic [N-1:0]     done_matrix_o;
   logic             busy_o;
   logic [N-1:0]     overrun_err_o;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   // Reference model: pops still owed per lane, plus status flags.
   longint unsigned m_rem[N];
   bit              m_act[N];
   bit              m_done[N];
   bit              m_err[N];

   fifo_pop_sequencer #(.NUM_FIFO(N), .CNT_W(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .need_pop_i    (need_pop_i),
      .pop_num_i     (pop_num_i),
      .clear_i       (clear_i),
      .fifo_empty_i  (fifo_empty_i),
      .pe_ready_i    (pe_ready_i),
      .pop_o         (pop_o),
      .done_matrix_o (done_matrix_o),
      .busy_o        (busy_o),
      .overrun_err_o (overrun_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_rem[i] = 0; m_act[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic drive(input logic [N-1:0] need, input logic [N*W-1:0] nums,
                        input logic [N-1:0] empty, input logic [N-1:0] ready,
                        input logic clr, input logic rstn);
      exp_t e;
      @(negedge clk);
      rst_n        = rstn;
      need_pop_i   = need;
      pop_num_i    = nums;
      fifo_empty_i = empty;
      pe_ready_i   = ready;
      clear_i      = clr;
      if (!rstn) model_clear();
      e = '0;
      for (int i = 0; i < N; i++) begin
         e.pop[i]  = rstn && !clr && m_act[i] && !empty[i] && ready[i];
         e.done[i] = m_done[i];
         e.err[i]  = m_err[i];
         e.busy    = e.busy | m_act[i];
      end
      exp_q.push_back(e);
      if (!rstn || clr) begin
         model_clear();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
               if (need[i]) m_err[i] = 1;
               if (e.pop[i]) begin
                  m_rem[i] = m_rem[i] - 1;
                  if (m_rem[i] == 0) begin
                     m_act[i]  = 0;
                     m_done[i] = 1;
                  end
               end
            end else if (need[i]) begin
               m_rem[i] = longint'(nums[i*W +: W]);
               if (m_rem[i] != 0) begin
                  m_act[i]  = 1;
                  m_done[i] = 0;
               end else begin
                  m_done[i] = 1;
               end
            end
         end
      end
   endtask

   task automatic idle(input int n, input logic [N-1:0] empty, input logic [N-1:0] ready);
      for (int k = 0; k < n; k++) drive('0, '0, empty, ready, 1'b0, 1'b1);
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pop_o !== e.pop) begin
               failures++;
               $display("FAIL pop_o: got %h required %h at %0t", pop_o, e.pop, $time);
            end
            checks++;
            if (done_matrix_o !== e.done) begin
               failures++;
               $display("FAIL done_matrix_o: got %h required %h at %0t", done_matrix_o, e.done, $time);
            end
            checks++;
            if (overrun_err_o !== e.err) begin
               failures++;
               $display("FAIL overrun_err_o: got %h required %h at %0t", overrun_err_o, e.err, $time);
            end
            checks++;
            if (busy_o !== e.busy) begin
               failures++;
               $display("FAIL busy_o: got %b required %b at %0t", busy_o, e.busy, $time);
            end
         end
      end
   end

   initial begin
      logic [N*W-1:0] nv;
      logic [N-1:0]   nd;
      logic [N-1:0]   em;
      logic [N-1:0]   rd;

      rst_n = 1'b0; need_pop_i = '0; pop_num_i = '0; clear_i = 1'b0;
      fifo_empty_i = '0; pe_ready_i = '0;
      model_clear();

      // Reset state
      drive('0, '0, '0, '1, 1'b0, 1'b0);
      drive('1, '1, '0, '1, 1'b0, 1'b0);
      idle(2, '0, '1);

      // Pointwise: one pop on every lane
      nv = '0;
      for (int i = 0; i < N; i++) nv[i*W +: W] = W'(1);
      drive('1, nv, '0, '1, 1'b0, 1'b1);
      idle(3, '0, '1);

      // Depthwise: lanes 0-29 get 3,3,3,6,...,30; lanes 30-31 get zero
      nv = '0;
      for (int i = 0; i < 30; i++) nv[i*W +: W] = W'(3 * (i / 3 + 1));
      drive('1, nv, '0, '1, 1'b0, 1'b1);
      idle(34, '0, '1);
      drive('0, '0, '0, '1, 1'b1, 1'b1);

      // Stall: lane 5 with toggling empty flag
      nv = '0; nv[5*W +: W] = W'(4);
      nd = '0; nd[5] = 1'b1;
      drive(nd, nv, '1, '1, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         em = '1; em[5] = (k % 2 == 0);
         drive('0, '0, em, '1, 1'b0, 1'b1);
      end

      // Backpressure: lane 7 held off for 10 cycles
      nv = '0; nv[7*W +: W] = W'(2);
      nd = '0; nd[7] = 1'b1;
      rd = '1; rd[7] = 1'b0;
      drive(nd, nv, '0, rd, 1'b0, 1'b1);
      idle(10, '0, rd);
      idle(4, '0, '1);

      // Overrun then clear: lane 3 reloaded while counting 5
      nv = '0; nv[3*W +: W] = W'(5);
      nd = '0; nd[3] = 1'b1;
      drive(nd, nv, '1, '1, 1'b0, 1'b1);
      nv[3*W +: W] = W'(9);
      drive(nd, nv, '1, '1, 1'b0, 1'b1);
      idle(8, '0, '1);
      drive('0, '0, '0, '1, 1'b1, 1'b1);
      idle(2, '0, '1);

      // Clear while counting: pop must be suppressed that cycle
      nv = '0; nv[2*W +: W] = W'(6);
      nd = '0; nd[2] = 1'b1;
      drive(nd, nv, '0, '1, 1'b0, 1'b1);
      idle(2, '0, '1);
      drive(nd, nv, '0, '1, 1'b1, 1'b1);
      idle(3, '0, '1);

      // Reset mid-operation: lane 0 counting 10
      nv = '0; nv[0*W +: W] = W'(10);
      nd = '0; nd[0] = 1'b1;
      drive(nd, nv, '0, '1, 1'b0, 1'b1);
      idle(3, '0, '1);
      drive('0, '0, '0, '1, 1'b0, 1'b0);
      idle(4, '0, '1);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         nv = '0; nd = '0;
         for (int i = 0; i < N; i++) begin
            nd[i] = ($urandom % 10) == 0;
            nv[i*W +: W] = W'($urandom_range(0, 5));
         end
         em = $urandom & $urandom;
         rd = $urandom | $urandom;
         drive(nd, nv, em, rd, ($urandom % 100) == 0, ($urandom % 150) != 0);
      end
      idle(2, '0, '1);

      @(negedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
